// File: rtl/divmon_pkg.sv
// divmon_pkg: shared state type, default constants and helpers for div_clk_monitor.
`default_nettype none

package divmon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      MEAS  = 2'd2
   } divmon_state_t;

   localparam int DIVMON_CNT_W      = 16;
   localparam int DIVMON_EXP_PERIOD = 10;

   function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous level plus one-cycle rise/fall pulses.
`default_nettype none

module sync_edge (
   input  logic clk_in,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

`default_nettype wire

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of a divided clock and reports lock to EXP_PERIOD.
// Optional stall detection is built when DIVMON_TIMEOUT_EN is defined.
`default_nettype none

module div_clk_monitor
   import divmon_pkg::*;
#(
   parameter int CNT_W      = DIVMON_CNT_W,
   parameter int EXP_PERIOD = DIVMON_EXP_PERIOD,
   parameter int TOL        = 0,
   parameter int LOCK_CNT   = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             stall
);

   localparam int               MC_W    = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [MC_W-1:0]  LOCK_V  = MC_W'(LOCK_CNT);

   logic             s2;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [MC_W-1:0]  match_cnt;
   logic [MC_W-1:0]  match_cnt_next;
   logic             match;
   divmon_state_t    state;

   sync_edge u_sync_edge (
      .clk_in (clk_in),
      .reset  (reset),
      .din    (sig_in),
      .level  (s2),
      .rise   (rise),
      .fall   (fall)
   );

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // A saturated counter means the real period is unknown, so it can never match.
   assign match = (cnt != CNT_MAX) &&
                  (abs_diff(32'(cnt), EXP_PERIOD) <= TOL);

   assign match_cnt_next = !match              ? '0 :
                           (match_cnt == LOCK_V) ? match_cnt :
                                                   match_cnt + 1'b1;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         hcnt       <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         match_cnt  <= '0;
         locked     <= 1'b0;
`ifdef DIVMON_TIMEOUT_EN
         stall      <= 1'b0;
`endif
      end else begin
         meas_valid <= 1'b0;
         locked     <= (match_cnt == LOCK_V);
         cnt        <= rise ? CNT_W'(1) : cnt_inc;

         if (rise) begin
            hcnt <= CNT_W'(1);
         end else if (s2 && (hcnt != CNT_MAX)) begin
            hcnt <= hcnt + 1'b1;
         end

         if (fall && (state != IDLE)) begin
            high_time <= hcnt;
         end

         if (rise) begin
`ifdef DIVMON_TIMEOUT_EN
            stall <= 1'b0;
`endif
            if (state == IDLE) begin
               state <= FIRST;
            end else begin
               state      <= MEAS;
               period     <= cnt;
               meas_valid <= 1'b1;
               match_cnt  <= match_cnt_next;
            end
         end
`ifdef DIVMON_TIMEOUT_EN
         else if (32'(cnt_inc) == TIMEOUT && cnt != cnt_inc) begin
            // Lost edge: restart from IDLE so the next rise is only a reference.
            stall     <= 1'b1;
            state     <= IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
         end
`endif
      end
   end

`ifndef DIVMON_TIMEOUT_EN
   assign stall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: directed stimulus, queued expectations, independent output monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_div_clk_monitor;

   typedef struct packed {
      logic [15:0] per;
      logic [15:0] ht;
      logic        lk;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b0;
   logic [1:0]  sig    = 2'b00;

   logic [15:0] per_a, ht_a;
   logic        mv_a, lk_a, st_a;
   logic [3:0]  per_b, ht_b;
   logic        mv_b, lk_b, st_b;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mc[2];
   int   have_prev[2];
   int   prev_h[2];
   int   prev_l[2];
   logic pend[2];
   logic exp_lk[2];

   always #5 clk_in = ~clk_in;

   div_clk_monitor u_dut_a (
      .clk_in(clk_in), .reset(reset), .sig_in(sig[0]),
      .period(per_a), .high_time(ht_a), .meas_valid(mv_a), .locked(lk_a), .stall(st_a)
   );

   div_clk_monitor #(.CNT_W(4), .EXP_PERIOD(10), .TOL(1), .LOCK_CNT(4), .TIMEOUT(64)) u_dut_b (
      .clk_in(clk_in), .reset(reset), .sig_in(sig[1]),
      .period(per_b), .high_time(ht_b), .meas_valid(mv_b), .locked(lk_b), .stall(st_b)
   );

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected result of the measurement closed by a rise on channel i.
   task automatic rise_evt(input int i);
      int   maxv;
      int   tol;
      int   p;
      int   h;
      int   d;
      bit   m;
      exp_t e;
      maxv = (i == 0) ? 65535 : 15;
      tol  = (i == 0) ? 0 : 1;
      if (have_prev[i] != 0) begin
         p = prev_h[i] + prev_l[i];
         if (p > maxv) p = maxv;
         h = (prev_h[i] > maxv) ? maxv : prev_h[i];
         d = (p > 10) ? p - 10 : 10 - p;
         m = (p != maxv) && (d <= tol);
         mc[i] = m ? ((mc[i] < 4) ? mc[i] + 1 : 4) : 0;
         e.per = 16'(p);
         e.ht  = 16'(h);
         e.lk  = (mc[i] == 4);
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Called at a negedge; drives n periods of h high / l low cycles.
   task automatic run(input int i, input int h, input int l, input int n);
      repeat (n) begin
         sig[i] = 1'b1;
         rise_evt(i);
         have_prev[i] = 1;
         prev_h[i]    = h;
         prev_l[i]    = l;
         repeat (h) @(negedge clk_in);
         sig[i] = 1'b0;
         repeat (l) @(negedge clk_in);
      end
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (pend[0]) chk("locked_a", int'(lk_a), int'(exp_lk[0]));
      if (pend[1]) chk("locked_b", int'(lk_b), int'(exp_lk[1]));
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      if (mv_a) begin
         if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_mv_a: got meas_valid=1 period=%0d, required no measurement", per_a);
         end else begin
            e = q0.pop_front();
            chk("period_a", int'(per_a), int'(e.per));
            chk("high_time_a", int'(ht_a), int'(e.ht));
            exp_lk[0] = e.lk;
            pend[0]   = 1'b1;
         end
      end
      if (mv_b) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_mv_b: got meas_valid=1 period=%0d, required no measurement", per_b);
         end else begin
            e = q1.pop_front();
            chk("period_b", int'(per_b), int'(e.per));
            chk("high_time_b", int'(ht_b), int'(e.ht));
            exp_lk[1] = e.lk;
            pend[1]   = 1'b1;
         end
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         mc[i] = 0; have_prev[i] = 0; prev_h[i] = 0; prev_l[i] = 0;
         pend[i] = 1'b0; exp_lk[i] = 1'b0;
      end
      repeat (3) @(negedge clk_in);
      chk("reset_period", int'(per_a), 0);
      chk("reset_high_time", int'(ht_a), 0);
      chk("reset_meas_valid", int'(mv_a), 0);
      chk("reset_locked", int'(lk_a), 0);
      chk("reset_stall", int'(st_a), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk_in);

      // divide-by-10, then period 12 which must drop and keep lock off
      run(0, 5, 5, 6);
      chk("locked_after_4_meas", int'(lk_a), 1);
      run(0, 6, 6, 5);
      chk("unlocked_at_12", int'(lk_a), 0);
      run(0, 5, 5, 6);

`ifdef DIVMON_TIMEOUT_EN
      repeat (70) @(negedge clk_in);
      chk("stall_set", int'(st_a), 1);
      chk("stall_drops_lock", int'(lk_a), 0);
      have_prev[0] = 0;
      mc[0]        = 0;
      run(0, 5, 5, 1);
      chk("stall_cleared", int'(st_a), 0);
      run(0, 5, 5, 5);
      chk("relock_after_stall", int'(lk_a), 1);
`endif

      // async reset in the middle of a high phase
      sig[0] = 1'b1;
      rise_evt(0);
      have_prev[0] = 1;
      repeat (6) @(negedge clk_in);
      #2 reset = 1'b0;
      #1;
      chk("async_period", int'(per_a), 0);
      chk("async_high_time", int'(ht_a), 0);
      chk("async_locked", int'(lk_a), 0);
      chk("async_meas_valid", int'(mv_a), 0);
      chk("async_stall", int'(st_a), 0);
      chk("queue_drained_a", q0.size(), 0);
      have_prev[0] = 0;
      mc[0]        = 0;
      sig[0]       = 1'b0;
      @(negedge clk_in);
      reset = 1'b1;
      @(negedge clk_in);
      run(0, 5, 5, 3);

      // narrow-counter instance: tolerance 1, then saturation at 15
      have_prev[1] = 0;
      mc[1]        = 0;
      run(1, 5, 5, 6);
      chk("b_locked_at_10", int'(lk_b), 1);
      run(1, 6, 5, 4);
      chk("b_locked_at_11", int'(lk_b), 1);
      run(1, 20, 20, 3);
      chk("b_unlocked_saturated", int'(lk_b), 0);

      repeat (8) @(negedge clk_in);
      chk("queue_empty_a", q0.size(), 0);
      chk("queue_empty_b", q1.size(), 0);
`ifndef DIVMON_TIMEOUT_EN
      chk("stall_off_a", int'(st_a), 0);
      chk("stall_off_b", int'(st_b), 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
